// File: rtl/arduino_tone_receiver.sv
// Far-end receiver for the 3-bit note link: synchronise, deglitch, decode the
// note code and drive a square-wave tone on a buzzer pin.
module arduino_tone_receiver #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned DIV_SHIFT     = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] note_code,
    input  logic       enable,
    output logic [6:0] note_onehot,
    output logic       note_valid,
    output logic       playing,
    output logic       tone
);

    localparam int unsigned CW = 8;
    localparam int unsigned PW = 17;
    localparam logic [CW-1:0] COUNT_MAX = CW'(STABLE_CYCLES - 1);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t          state;
    logic [2:0]      sync1, sync2, candidate, accepted;
    logic [CW-1:0]   count;
    logic [PW-1:0]   phase;

    logic [2:0]      candidate_next, accepted_next;
    logic [CW-1:0]   count_next;
    logic [PW-1:0]   half;

    // Half-period in clock cycles for a note code, scaled and clamped to >= 2.
    function automatic logic [PW-1:0] half_of(input logic [2:0] code);
        logic [PW-1:0] raw;
        logic [PW-1:0] scaled;
        case (code)
            3'd1:    raw = PW'(95556);
            3'd2:    raw = PW'(85131);
            3'd3:    raw = PW'(75843);
            3'd4:    raw = PW'(71586);
            3'd5:    raw = PW'(63776);
            3'd6:    raw = PW'(56818);
            3'd7:    raw = PW'(50619);
            default: raw = PW'(2);
        endcase
        scaled = raw >> DIV_SHIFT;
        if (scaled < PW'(2)) scaled = PW'(2);
        return scaled;
    endfunction

    function automatic logic [6:0] onehot_of(input logic [2:0] code);
        logic [6:0] oh;
        for (int i = 0; i < 7; i++) oh[i] = (code == 3'(i + 1));
        return oh;
    endfunction

    assign half = half_of(accepted);

    // Stability filter; acceptance lands on the edge the counter reaches its limit.
    always_comb begin
        candidate_next = candidate;
        count_next     = count;
        accepted_next  = accepted;
        if (sync2 != candidate) begin
            candidate_next = sync2;
            count_next     = '0;
        end else if (count != COUNT_MAX) begin
            count_next = count + CW'(1);
        end
        if (sync2 == candidate && count_next == COUNT_MAX && candidate != accepted)
            accepted_next = candidate;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1       <= '0;
            sync2       <= '0;
            candidate   <= '0;
            count       <= '0;
            accepted    <= '0;
            state       <= IDLE;
            phase       <= '0;
            note_onehot <= '0;
            note_valid  <= 1'b0;
            playing     <= 1'b0;
            tone        <= 1'b0;
        end else begin
            sync1       <= note_code;
            sync2       <= sync1;
            candidate   <= candidate_next;
            count       <= count_next;
            accepted    <= accepted_next;
            note_onehot <= onehot_of(accepted_next);
            note_valid  <= (accepted_next != accepted) && (accepted_next != 3'd0);

            case (state)
                IDLE: begin
                    tone  <= 1'b0;
                    phase <= '0;
                    if (accepted_next != 3'd0 && enable) begin
                        state   <= PLAY;
                        playing <= 1'b1;
                    end else begin
                        playing <= 1'b0;
                    end
                end
                PLAY: begin
                    // Mute or silence wins over any simultaneous note change.
                    if (accepted_next == 3'd0 || !enable) begin
                        state   <= IDLE;
                        playing <= 1'b0;
                        tone    <= 1'b0;
                        phase   <= '0;
                    end else if (accepted_next != accepted) begin
                        phase <= '0;
                        tone  <= 1'b0;
                    end else if (phase == half - PW'(1)) begin
                        phase <= '0;
                        tone  <= ~tone;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    playing <= 1'b0;
                    tone    <= 1'b0;
                    phase   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arduino_tone_receiver.sv
// Directed bench for arduino_tone_receiver with STABLE_CYCLES=4, DIV_SHIFT=10.
module tb_arduino_tone_receiver;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] note_code;
    logic       enable;
    logic [6:0] note_onehot;
    logic       note_valid;
    logic       playing;
    logic       tone;

    int vectors = 0;
    int errors  = 0;
    int valid_seen = 0;

    arduino_tone_receiver #(.STABLE_CYCLES(4), .DIV_SHIFT(10)) dut (
        .clock(clock),
        .reset(reset),
        .note_code(note_code),
        .enable(enable),
        .note_onehot(note_onehot),
        .note_valid(note_valid),
        .playing(playing),
        .tone(tone)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (!reset && note_valid) valid_seen++;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; note_code = 3'd0; enable = 1'b0;
        step(3);
        vectors++; if (note_onehot !== 7'b0) begin errors++; $display("FAIL reset_onehot: got %b want %b", note_onehot, 7'b0); end
        vectors++; if (note_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", note_valid); end
        vectors++; if (playing !== 1'b0) begin errors++; $display("FAIL reset_playing: got %b want 0", playing); end
        vectors++; if (tone !== 1'b0) begin errors++; $display("FAIL reset_tone: got %b want 0", tone); end
        reset = 1'b0; enable = 1'b1;
        step(8);
    endtask

    task automatic test_glitch();
        int v0 = valid_seen;
        note_code = 3'd3;
        step(2);
        note_code = 3'd0;
        step(10);
        vectors++; if (note_onehot !== 7'b0) begin errors++; $display("FAIL glitch_onehot: got %b want %b", note_onehot, 7'b0); end
        vectors++; if (playing !== 1'b0) begin errors++; $display("FAIL glitch_playing: got %b want 0", playing); end
        vectors++; if (tone !== 1'b0) begin errors++; $display("FAIL glitch_tone: got %b want 0", tone); end
        vectors++; if (valid_seen - v0 !== 0) begin errors++; $display("FAIL glitch_valid_count: got %0d want 0", valid_seen - v0); end
    endtask

    task automatic test_play();
        int v0 = valid_seen;
        note_code = 3'd6;
        step(5);
        vectors++; if (note_onehot !== 7'b0) begin errors++; $display("FAIL play_early_onehot: got %b want %b", note_onehot, 7'b0); end
        vectors++; if (playing !== 1'b0) begin errors++; $display("FAIL play_early_playing: got %b want 0", playing); end
        step(1);
        vectors++; if (note_onehot !== 7'b0100000) begin errors++; $display("FAIL play_onehot: got %b want %b", note_onehot, 7'b0100000); end
        vectors++; if (note_valid !== 1'b1) begin errors++; $display("FAIL play_valid: got %b want 1", note_valid); end
        vectors++; if (playing !== 1'b1) begin errors++; $display("FAIL play_playing: got %b want 1", playing); end
        step(54);
        vectors++; if (tone !== 1'b0) begin errors++; $display("FAIL play_tone_before_rise: got %b want 0", tone); end
        step(1);
        vectors++; if (tone !== 1'b1) begin errors++; $display("FAIL play_tone_rise: got %b want 1", tone); end
        step(54);
        vectors++; if (tone !== 1'b1) begin errors++; $display("FAIL play_tone_high: got %b want 1", tone); end
        step(1);
        vectors++; if (tone !== 1'b0) begin errors++; $display("FAIL play_tone_fall: got %b want 0", tone); end
        vectors++; if (valid_seen - v0 !== 1) begin errors++; $display("FAIL play_valid_count: got %0d want 1", valid_seen - v0); end
    endtask

    task automatic test_change();
        int v0 = valid_seen;
        note_code = 3'd1;
        step(6);
        vectors++; if (note_onehot !== 7'b0000001) begin errors++; $display("FAIL change1_onehot: got %b want %b", note_onehot, 7'b0000001); end
        vectors++; if (note_valid !== 1'b1) begin errors++; $display("FAIL change1_valid: got %b want 1", note_valid); end
        step(92);
        vectors++; if (tone !== 1'b0) begin errors++; $display("FAIL change1_tone_before_rise: got %b want 0", tone); end
        step(1);
        vectors++; if (tone !== 1'b1) begin errors++; $display("FAIL change1_tone_rise: got %b want 1", tone); end
        step(10);
        note_code = 3'd7;
        step(5);
        vectors++; if (tone !== 1'b1) begin errors++; $display("FAIL change7_tone_held: got %b want 1", tone); end
        step(1);
        vectors++; if (note_onehot !== 7'b1000000) begin errors++; $display("FAIL change7_onehot: got %b want %b", note_onehot, 7'b1000000); end
        vectors++; if (note_valid !== 1'b1) begin errors++; $display("FAIL change7_valid: got %b want 1", note_valid); end
        vectors++; if (tone !== 1'b0) begin errors++; $display("FAIL change7_tone_restart: got %b want 0", tone); end
        vectors++; if (playing !== 1'b1) begin errors++; $display("FAIL change7_playing: got %b want 1", playing); end
        step(48);
        vectors++; if (tone !== 1'b0) begin errors++; $display("FAIL change7_tone_before_rise: got %b want 0", tone); end
        step(1);
        vectors++; if (tone !== 1'b1) begin errors++; $display("FAIL change7_tone_rise: got %b want 1", tone); end
        vectors++; if (valid_seen - v0 !== 2) begin errors++; $display("FAIL change_valid_count: got %0d want 2", valid_seen - v0); end
    endtask

    task automatic test_mute();
        int v0 = valid_seen;
        enable = 1'b0;
        step(1);
        vectors++; if (playing !== 1'b0) begin errors++; $display("FAIL mute_playing: got %b want 0", playing); end
        vectors++; if (tone !== 1'b0) begin errors++; $display("FAIL mute_tone: got %b want 0", tone); end
        vectors++; if (note_onehot !== 7'b1000000) begin errors++; $display("FAIL mute_onehot: got %b want %b", note_onehot, 7'b1000000); end
        step(19);
        enable = 1'b1;
        step(1);
        vectors++; if (playing !== 1'b1) begin errors++; $display("FAIL unmute_playing: got %b want 1", playing); end
        step(48);
        vectors++; if (tone !== 1'b0) begin errors++; $display("FAIL unmute_tone_before_rise: got %b want 0", tone); end
        step(1);
        vectors++; if (tone !== 1'b1) begin errors++; $display("FAIL unmute_tone_rise: got %b want 1", tone); end
        vectors++; if (valid_seen - v0 !== 0) begin errors++; $display("FAIL mute_valid_count: got %0d want 0", valid_seen - v0); end
    endtask

    task automatic test_silence();
        int v0 = valid_seen;
        note_code = 3'd0;
        step(5);
        vectors++; if (playing !== 1'b1) begin errors++; $display("FAIL silence_early_playing: got %b want 1", playing); end
        step(1);
        vectors++; if (note_onehot !== 7'b0) begin errors++; $display("FAIL silence_onehot: got %b want %b", note_onehot, 7'b0); end
        vectors++; if (playing !== 1'b0) begin errors++; $display("FAIL silence_playing: got %b want 0", playing); end
        vectors++; if (tone !== 1'b0) begin errors++; $display("FAIL silence_tone: got %b want 0", tone); end
        vectors++; if (valid_seen - v0 !== 0) begin errors++; $display("FAIL silence_valid_count: got %0d want 0", valid_seen - v0); end
    endtask

    task automatic test_async_reset();
        note_code = 3'd4;
        step(6);
        vectors++; if (playing !== 1'b1) begin errors++; $display("FAIL areset_pre_playing: got %b want 1", playing); end
        step(69);
        vectors++; if (tone !== 1'b1) begin errors++; $display("FAIL areset_pre_tone: got %b want 1", tone); end
        #2 reset = 1'b1;
        #1;
        vectors++; if (tone !== 1'b0) begin errors++; $display("FAIL areset_tone: got %b want 0", tone); end
        vectors++; if (playing !== 1'b0) begin errors++; $display("FAIL areset_playing: got %b want 0", playing); end
        vectors++; if (note_onehot !== 7'b0) begin errors++; $display("FAIL areset_onehot: got %b want %b", note_onehot, 7'b0); end
        step(2);
        reset = 1'b0;
        step(5);
        vectors++; if (note_onehot !== 7'b0) begin errors++; $display("FAIL areset_early_onehot: got %b want %b", note_onehot, 7'b0); end
        vectors++; if (note_valid !== 1'b0) begin errors++; $display("FAIL areset_early_valid: got %b want 0", note_valid); end
        step(1);
        vectors++; if (note_onehot !== 7'b0001000) begin errors++; $display("FAIL areset_onehot_after: got %b want %b", note_onehot, 7'b0001000); end
        vectors++; if (note_valid !== 1'b1) begin errors++; $display("FAIL areset_valid_after: got %b want 1", note_valid); end
        vectors++; if (playing !== 1'b1) begin errors++; $display("FAIL areset_playing_after: got %b want 1", playing); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_play();
        test_change();
        test_mute();
        test_silence();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
